// File: rtl/seriallite3_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seriallite3_pkg
// Brief   : Shared widths, sync-field positions and beat record for the
//           SerialLite III TX burst packer.
// Revision: 1.0
// ============================================================================
package seriallite3_pkg;

  localparam int LANES          = 4;
  localparam int WORD_W         = 64;
  localparam int BEAT_W         = 256;
  localparam int SYNC_W         = 8;
  localparam int SYNC_WORDS_LSB = 0;
  localparam int SYNC_CONT_BIT  = 3;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic              sob;
    logic              eob;
    logic [SYNC_W-1:0] sync;
  } sl3_beat_t;

  localparam int SL3_BEAT_BITS = $bits(sl3_beat_t);

endpackage
`default_nettype wire

// File: rtl/seriallite3_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module  : seriallite3_beat_fifo
// Brief   : Two-entry beat FIFO; the head entry is a register driven straight
//           to the outputs.
// Revision: 1.0
// ============================================================================
module seriallite3_beat_fifo
  import seriallite3_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [SL3_BEAT_BITS-1:0] i_din,
  input  logic                     i_pop,
  output logic [SL3_BEAT_BITS-1:0] o_head,
  output logic                     o_full,
  output logic                     o_empty
);

  sl3_beat_t  r_head;
  sl3_beat_t  r_tail;
  logic [1:0] r_count;
  logic       w_pop_ok;
  logic       w_push_ok;
  sl3_beat_t  w_din;

  assign w_din     = sl3_beat_t'(i_din);
  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b11: begin
          // Count is unchanged; the new beat lands behind whatever remains.
          if (r_count == 2'd1) begin
            r_head <= w_din;
          end else begin
            r_head <= r_tail;
            r_tail <= w_din;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_din;
          else                 r_tail <= w_din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/seriallite3_tx_burst_packer.sv
`default_nettype none
// ============================================================================
// Module  : seriallite3_tx_burst_packer
// Brief   : Packs a 64-bit word stream into 256-bit beats and bounded-length
//           bursts for the SerialLite III user TX interface.
// Revision: 1.0
// ============================================================================
module seriallite3_tx_burst_packer
  import seriallite3_pkg::*;
#(
  parameter int MAX_BURST_BEATS = 16
) (
  input  logic         user_clock_tx,
  input  logic         user_clock_reset_tx_n,
  input  logic [63:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [255:0] data_tx,
  output logic         valid_tx,
  input  logic         ready_tx,
  output logic         start_of_burst_tx,
  output logic         end_of_burst_tx,
  output logic [7:0]   sync_tx,
  input  logic         link_up_tx,
  output logic [31:0]  bursts_sent
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } burst_state_t;

  burst_state_t                   r_state;
  burst_state_t                   w_state_nxt;
  logic [LANES-1:0][WORD_W-1:0]   r_pack;
  logic [1:0]                     r_lane;
  logic [7:0]                     r_beat_cnt;
  logic [7:0]                     w_beat_cnt_nxt;
  logic                           r_cont_pending;
  logic                           w_cont_nxt;
  logic                           r_run;
  logic [31:0]                    r_bursts;

  sl3_beat_t                      w_fifo_din;
  sl3_beat_t                      w_head;
  logic [SL3_BEAT_BITS-1:0]       w_head_bits;
  logic [BEAT_W-1:0]              w_beat_data;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_full;
  logic                           w_empty;
  logic                           w_fifo_space;
  logic                           w_close;
  logic                           w_accept;
  logic                           w_limit;
  logic                           w_in_ready;

  // A word closes its beat when it fills lane 3 or ends the packet; the burst
  // limit only ever coincides with one of those closes.
  assign w_close      = (r_lane == 2'd3) || in_last;
  assign w_pop        = !w_empty && link_up_tx && ready_tx;
  assign w_fifo_space = !w_full || w_pop;
  assign w_in_ready   = r_run && link_up_tx && (!w_close || w_fifo_space);
  assign w_accept     = in_valid && w_in_ready;
  assign w_limit      = (({1'b0, r_beat_cnt} + 9'd1) == 9'(MAX_BURST_BEATS));

  always_comb begin
    w_beat_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k == int'(r_lane))     w_beat_data[k*WORD_W +: WORD_W] = in_data;
      else if (k < int'(r_lane)) w_beat_data[k*WORD_W +: WORD_W] = r_pack[k];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_cont_nxt      = r_cont_pending;
    w_push          = 1'b0;
    w_fifo_din      = '0;
    w_fifo_din.data = w_beat_data;
    if (w_accept && w_close) begin
      w_push         = 1'b1;
      w_fifo_din.sob = (r_state == ST_IDLE);
      w_fifo_din.eob = in_last || w_limit;
      if (r_state == ST_IDLE) begin
        w_fifo_din.sync[SYNC_CONT_BIT] = r_cont_pending;
        w_cont_nxt                     = 1'b0;
      end
      if (in_last) begin
        w_fifo_din.sync[SYNC_WORDS_LSB +: 3] = {1'b0, r_lane} + 3'd1;
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = 8'd0;
        w_cont_nxt     = 1'b0;
      end else if (w_limit) begin
        w_fifo_din.sync[SYNC_WORDS_LSB +: 3] = 3'd4;
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = 8'd0;
        w_cont_nxt     = 1'b1;
      end else begin
        w_state_nxt    = ST_OPEN;
        w_beat_cnt_nxt = r_beat_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
    if (!user_clock_reset_tx_n) begin
      r_state        <= ST_IDLE;
      r_beat_cnt     <= 8'd0;
      r_cont_pending <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat_cnt     <= w_beat_cnt_nxt;
      r_cont_pending <= w_cont_nxt;
    end
  end

  always_ff @(posedge user_clock_tx or negedge user_clock_reset_tx_n) begin
    if (!user_clock_reset_tx_n) begin
      r_pack   <= '0;
      r_lane   <= 2'd0;
      r_run    <= 1'b0;
      r_bursts <= 32'd0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        if (w_close) begin
          r_pack <= '0;
          r_lane <= 2'd0;
        end else begin
          r_pack[r_lane] <= in_data;
          r_lane         <= r_lane + 2'd1;
        end
      end
      if (w_pop && w_head.eob) r_bursts <= r_bursts + 32'd1;
    end
  end

  seriallite3_beat_fifo u_fifo (
    .clk     (user_clock_tx),
    .rst_n   (user_clock_reset_tx_n),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_head  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head            = sl3_beat_t'(w_head_bits);
  assign in_ready          = w_in_ready;
  assign data_tx           = w_head.data;
  assign valid_tx          = !w_empty && link_up_tx;
  assign start_of_burst_tx = w_head.sob;
  assign end_of_burst_tx   = w_head.eob;
  assign sync_tx           = w_head.sync;
  assign bursts_sent       = r_bursts;

endmodule
`default_nettype wire

// File: tb/tb_seriallite3_tx_burst_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_seriallite3_tx_burst_packer
// Brief   : Randomized scoreboard bench for the TX burst packer.
// Revision: 1.0
// ============================================================================
module tb_seriallite3_tx_burst_packer;

  localparam int MAX = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [255:0] data_tx;
  logic         valid_tx;
  logic         ready_tx;
  logic         sob;
  logic         eob;
  logic [7:0]   sync_tx;
  logic         link_up;
  logic [31:0]  bursts_sent;

  always #5 clk = ~clk;

  seriallite3_tx_burst_packer #(.MAX_BURST_BEATS(MAX)) dut (
    .user_clock_tx         (clk),
    .user_clock_reset_tx_n (rst_n),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_last               (in_last),
    .in_ready              (in_ready),
    .data_tx               (data_tx),
    .valid_tx              (valid_tx),
    .ready_tx              (ready_tx),
    .start_of_burst_tx     (sob),
    .end_of_burst_tx       (eob),
    .sync_tx               (sync_tx),
    .link_up_tx            (link_up),
    .bursts_sent           (bursts_sent)
  );

  typedef struct {
    logic [255:0] data;
    logic         sob;
    logic         eob;
    logic [7:0]   sync;
  } exp_t;

  exp_t         exp_q[$];
  logic [63:0]  pkt_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_bursts = 0;
  bit           stall = 1'b0;

  task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Expected beats from the packet length alone: 4 words per beat, bursts of
  // MAX beats restarting at every packet, split bursts flagged on their start.
  task automatic model_packet();
    int nb;
    nb = (pkt_q.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      exp_t e;
      int   n;
      int   p;
      p      = b % MAX;
      n      = (b == nb - 1) ? pkt_q.size() - 4 * b : 4;
      e.data = '0;
      for (int k = 0; k < n; k++) e.data[64*k +: 64] = pkt_q[4*b + k];
      e.sob  = (p == 0);
      e.eob  = (b == nb - 1) || (p == MAX - 1);
      e.sync = '0;
      if (e.eob) e.sync[2:0] = (b == nb - 1) ? n[2:0] : 3'd4;
      if (e.sob && b > 0) e.sync[3] = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_packet(input int len, input int gap_pct, input bit real_pkt);
    bit acc;
    int guard;
    pkt_q.delete();
    for (int i = 0; i < len; i++) pkt_q.push_back({$urandom, $urandom});
    if (real_pkt) model_packet();
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = pkt_q[i];
      in_last  = real_pkt && (i == len - 1);
      acc      = 1'b0;
      guard    = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 2000) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout actual=0 required=1");
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    ready_tx = 1'b0;
    forever begin
      @(posedge clk); #1;
      ready_tx = stall ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  exp_t         e;
  bit           prev_stall = 1'b0;
  logic [265:0] prev_fields;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && valid_tx)
        chk("stable_fields", {6'd0, data_tx, sob, eob, sync_tx}, {6'd0, prev_fields});
      if (valid_tx && ready_tx) begin
        chk("bursts_sent_run", {240'd0, bursts_sent}, {240'd0, exp_bursts});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", data_tx);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {16'd0, data_tx}, {16'd0, e.data});
          chk("beat_sob",  {271'd0, sob},    {271'd0, e.sob});
          chk("beat_eob",  {271'd0, eob},    {271'd0, e.eob});
          chk("beat_sync", {264'd0, sync_tx}, {264'd0, e.sync});
          if (e.eob) exp_bursts = exp_bursts + 32'd1;
        end
      end
      prev_stall  = valid_tx && !ready_tx;
      prev_fields = {data_tx, sob, eob, sync_tx};
    end
  end

  initial begin
    rst_n    = 1'b0;
    link_up  = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {271'd0, in_ready}, 272'd0);
    chk("rst_valid_tx", {271'd0, valid_tx}, 272'd0);
    chk("rst_data_tx",  {16'd0, data_tx},   272'd0);
    chk("rst_sob",      {271'd0, sob},      272'd0);
    chk("rst_eob",      {271'd0, eob},      272'd0);
    chk("rst_sync",     {264'd0, sync_tx},  272'd0);
    chk("rst_bursts",   {240'd0, bursts_sent}, 272'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    drive_packet(4, 0, 1'b1);
    drain();
    chk("bursts_after_4w", {240'd0, bursts_sent}, 272'd1);
    drive_packet(6, 0, 1'b1);
    drive_packet(12, 0, 1'b1);
    drain();
    chk("bursts_after_split", {240'd0, bursts_sent}, 272'd4);

    stall = 1'b1;
    fork
      drive_packet(40, 0, 1'b1);
      begin
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", {271'd0, in_ready}, 272'd0);
        chk("stall_valid_tx", {271'd0, valid_tx}, 272'd1);
        stall = 1'b0;
      end
    join
    drain();

    fork
      drive_packet(30, 10, 1'b1);
      begin
        repeat (6) @(posedge clk);
        #1 link_up = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("linkdown_in_ready", {271'd0, in_ready}, 272'd0);
          chk("linkdown_valid_tx", {271'd0, valid_tx}, 272'd0);
        end
        @(posedge clk); #1;
        link_up = 1'b1;
      end
    join
    drain();

    for (int p = 0; p < 30; p++) drive_packet($urandom_range(24, 1), 20, 1'b1);
    drain();
    chk("bursts_total", {240'd0, bursts_sent}, {240'd0, exp_bursts});

    stall = 1'b1;
    drive_packet(6, 0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", {271'd0, in_ready}, 272'd0);
    chk("midrst_valid_tx", {271'd0, valid_tx}, 272'd0);
    chk("midrst_data_tx",  {16'd0, data_tx},   272'd0);
    chk("midrst_sob",      {271'd0, sob},      272'd0);
    chk("midrst_eob",      {271'd0, eob},      272'd0);
    chk("midrst_sync",     {264'd0, sync_tx},  272'd0);
    chk("midrst_bursts",   {240'd0, bursts_sent}, 272'd0);
    exp_q.delete();
    exp_bursts = 0;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive_packet(4, 0, 1'b1);
    drain();
    chk("bursts_after_rst", {240'd0, bursts_sent}, 272'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
